// File: rtl/bp_fe_lce_resp_arb.sv
// Merges the I-cache LCE's request-engine and command-engine responses onto one
// outbound LCE response channel. A registered 2-entry FIFO feeds the channel.
module bp_fe_lce_resp_arb #(
    parameter int resp_width_p   = 64,
    parameter int starve_limit_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [resp_width_p-1:0] req_resp_i,
    input  logic                    req_resp_v_i,
    output logic                    req_resp_yumi_o,
    input  logic [resp_width_p-1:0] cmd_resp_i,
    input  logic                    cmd_resp_v_i,
    output logic                    cmd_resp_yumi_o,
    output logic [resp_width_p-1:0] lce_resp_o,
    output logic                    lce_resp_v_o,
    input  logic                    lce_resp_ready_i,
    output logic                    starve_grant_o
);

    localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

    logic [resp_width_p-1:0] mem_q [2];
    logic [1:0]              count_q, count_d;
    logic                    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]     starve_q, starve_d;

    logic                    deq, space, force_cmd, enq;
    logic [resp_width_p-1:0] enq_data;

    // Outputs come only from storage, so v inputs never reach lce_resp_v_o.
    assign lce_resp_v_o = (count_q != 2'd0);
    assign lce_resp_o   = mem_q[rptr_q];

    assign deq       = lce_resp_v_o & lce_resp_ready_i;
    assign space     = (count_q != 2'd2) | deq;
    assign force_cmd = (starve_q == limit_lp) & cmd_resp_v_i;

    always_comb begin
        req_resp_yumi_o = 1'b0;
        cmd_resp_yumi_o = 1'b0;
        starve_grant_o  = 1'b0;
        if (!reset_i && space) begin
            if (force_cmd) begin
                cmd_resp_yumi_o = 1'b1;
                starve_grant_o  = 1'b1;
            end else if (req_resp_v_i) begin
                req_resp_yumi_o = 1'b1;
            end else if (cmd_resp_v_i) begin
                cmd_resp_yumi_o = 1'b1;
            end
        end
    end

    assign enq      = req_resp_yumi_o | cmd_resp_yumi_o;
    assign enq_data = cmd_resp_yumi_o ? cmd_resp_i : req_resp_i;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (enq) wptr_d = ~wptr_q;
        if (deq) rptr_d = ~rptr_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Counter tracks consecutive cycles a valid cmd source goes unserved.
    always_comb begin
        starve_d = starve_q;
        if (!cmd_resp_v_i || cmd_resp_yumi_o)
            starve_d = '0;
        else if (starve_q != limit_lp)
            starve_d = starve_q + cnt_w_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= 2'd0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            starve_q <= starve_d;
        end
    end

    // Storage needs no reset: count gates visibility of stale entries.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= enq_data;
    end

endmodule

// File: tb/tb_bp_fe_lce_resp_arb.sv
// Directed, table-driven check of the LCE response arbiter with a few
// hand-written reset sequences.
module tb_bp_fe_lce_resp_arb;

    localparam int W = 64;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] req_resp_i, cmd_resp_i, lce_resp_o;
    logic         req_resp_v_i, cmd_resp_v_i, lce_resp_ready_i;
    logic         req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starve_grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_lce_resp_arb #(.resp_width_p(W), .starve_limit_p(4)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .req_resp_i       (req_resp_i),
        .req_resp_v_i     (req_resp_v_i),
        .req_resp_yumi_o  (req_resp_yumi_o),
        .cmd_resp_i       (cmd_resp_i),
        .cmd_resp_v_i     (cmd_resp_v_i),
        .cmd_resp_yumi_o  (cmd_resp_yumi_o),
        .lce_resp_o       (lce_resp_o),
        .lce_resp_v_o     (lce_resp_v_o),
        .lce_resp_ready_i (lce_resp_ready_i),
        .starve_grant_o   (starve_grant_o)
    );

    typedef struct {
        logic         req_v;
        logic [W-1:0] req_d;
        logic         cmd_v;
        logic [W-1:0] cmd_d;
        logic         rdy;
        logic         e_ryumi;
        logic         e_cyumi;
        logic         e_sg;
        logic         e_v;
        logic [W-1:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rv, input int rd, input logic cv, input int cd,
                                input logic rdy, input logic ery, input logic ecy,
                                input logic esg, input logic ev, input int ed);
        vec_t v;
        v.req_v = rv;  v.req_d = W'(rd);
        v.cmd_v = cv;  v.cmd_d = W'(cd);
        v.rdy = rdy;   v.e_ryumi = ery; v.e_cyumi = ecy; v.e_sg = esg;
        v.e_v = ev;    v.e_data = W'(ed);
        tbl.push_back(v);
    endfunction

    task automatic check_outs(input string tag, input logic ery, input logic ecy,
                              input logic esg, input logic ev, input logic [W-1:0] ed);
        chk({tag, " req_yumi"}, W'(req_resp_yumi_o), W'(ery));
        chk({tag, " cmd_yumi"}, W'(cmd_resp_yumi_o), W'(ecy));
        chk({tag, " starve_grant"}, W'(starve_grant_o), W'(esg));
        chk({tag, " lce_v"}, W'(lce_resp_v_o), W'(ev));
        if (ev) chk({tag, " lce_data"}, lce_resp_o, ed);
    endtask

    // Inputs are driven just after posedge; everything is sampled at negedge.
    task automatic drive(input logic rv, input logic [W-1:0] rd, input logic cv,
                         input logic [W-1:0] cd, input logic rdy);
        req_resp_v_i = rv; req_resp_i = rd;
        cmd_resp_v_i = cv; cmd_resp_i = cd;
        lce_resp_ready_i = rdy;
    endtask

    initial begin
        reset_i = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b1);

        // single source + throughput
        add(1, 'hA5, 0, 0, 1,  1, 0, 0,  0, 0);
        add(0, 0,    0, 0, 1,  0, 0, 0,  1, 'hA5);
        add(0, 0,    0, 0, 1,  0, 0, 0,  0, 0);
        // backpressure: P2 accepted as P0 leaves
        add(1, 'h10, 0, 0, 0,  1, 0, 0,  0, 0);
        add(1, 'h11, 0, 0, 0,  1, 0, 0,  1, 'h10);
        add(1, 'h12, 0, 0, 0,  0, 0, 0,  1, 'h10);
        add(1, 'h12, 0, 0, 1,  1, 0, 0,  1, 'h10);
        add(0, 0,    0, 0, 1,  0, 0, 0,  1, 'h11);
        add(0, 0,    0, 0, 1,  0, 0, 0,  1, 'h12);
        add(0, 0,    0, 0, 1,  0, 0, 0,  0, 0);
        // starvation: period 5
        add(1, 'h20, 1, 'h30, 1,  1, 0, 0,  0, 0);
        add(1, 'h21, 1, 'h30, 1,  1, 0, 0,  1, 'h20);
        add(1, 'h22, 1, 'h30, 1,  1, 0, 0,  1, 'h21);
        add(1, 'h23, 1, 'h30, 1,  1, 0, 0,  1, 'h22);
        add(1, 'h24, 1, 'h30, 1,  0, 1, 1,  1, 'h23);
        add(1, 'h24, 1, 'h31, 1,  1, 0, 0,  1, 'h30);
        add(1, 'h25, 1, 'h31, 1,  1, 0, 0,  1, 'h24);
        add(1, 'h26, 1, 'h31, 1,  1, 0, 0,  1, 'h25);
        add(1, 'h27, 1, 'h31, 1,  1, 0, 0,  1, 'h26);
        add(1, 'h28, 1, 'h31, 1,  0, 1, 1,  1, 'h27);
        add(0, 0,    0, 0,    1,  0, 0, 0,  1, 'h31);
        add(0, 0,    0, 0,    1,  0, 0, 0,  0, 0);
        // idle cmd cycle clears the starvation count
        add(1, 'h40, 1, 'h50, 1,  1, 0, 0,  0, 0);
        add(1, 'h41, 1, 'h50, 1,  1, 0, 0,  1, 'h40);
        add(1, 'h42, 1, 'h50, 1,  1, 0, 0,  1, 'h41);
        add(1, 'h43, 0, 0,    1,  1, 0, 0,  1, 'h42);
        add(1, 'h44, 1, 'h50, 1,  1, 0, 0,  1, 'h43);
        add(1, 'h45, 1, 'h50, 1,  1, 0, 0,  1, 'h44);
        add(1, 'h46, 1, 'h50, 1,  1, 0, 0,  1, 'h45);
        add(1, 'h47, 1, 'h50, 1,  1, 0, 0,  1, 'h46);
        add(1, 'h48, 1, 'h50, 1,  0, 1, 1,  1, 'h47);
        add(0, 0,    0, 0,    1,  0, 0, 0,  1, 'h50);
        add(0, 0,    0, 0,    1,  0, 0, 0,  0, 0);
        // command only
        add(0, 0, 1, 'h60, 1,  0, 1, 0,  0, 0);
        add(0, 0, 1, 'h61, 1,  0, 1, 0,  1, 'h60);
        add(0, 0, 1, 'h62, 1,  0, 1, 0,  1, 'h61);
        add(0, 0, 0, 0,    1,  0, 0, 0,  1, 'h62);
        add(0, 0, 0, 0,    1,  0, 0, 0,  0, 0);
        // full + stalled: cmd still accrues starvation, force-granted on drain
        add(1, 'h70, 0, 0,    0,  1, 0, 0,  0, 0);
        add(1, 'h71, 0, 0,    0,  1, 0, 0,  1, 'h70);
        add(1, 'h72, 1, 'h80, 0,  0, 0, 0,  1, 'h70);
        add(1, 'h72, 1, 'h80, 0,  0, 0, 0,  1, 'h70);
        add(1, 'h72, 1, 'h80, 0,  0, 0, 0,  1, 'h70);
        add(1, 'h72, 1, 'h80, 0,  0, 0, 0,  1, 'h70);
        add(1, 'h72, 1, 'h80, 1,  0, 1, 1,  1, 'h70);
        add(1, 'h72, 0, 0,    1,  1, 0, 0,  1, 'h71);
        add(0, 0,    0, 0,    1,  0, 0, 0,  1, 'h80);
        add(0, 0,    0, 0,    1,  0, 0, 0,  1, 'h72);
        add(0, 0,    0, 0,    1,  0, 0, 0,  0, 0);

        // reset state, with sources asserting to prove yumi gating
        drive(1'b1, W'('h1), 1'b1, W'('h2), 1'b1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_outs("reset", 0, 0, 0, 0, '0);
        reset_i = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk_i); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req_v, tbl[i].req_d, tbl[i].cmd_v, tbl[i].cmd_d, tbl[i].rdy);
            @(negedge clk_i);
            check_outs($sformatf("vec%0d", i), tbl[i].e_ryumi, tbl[i].e_cyumi,
                       tbl[i].e_sg, tbl[i].e_v, tbl[i].e_data);
            @(posedge clk_i); #1;
        end

        // mid-stream reset with two packets buffered
        drive(1'b1, W'('h90), 1'b0, '0, 1'b0);
        @(negedge clk_i); check_outs("mr_fill0", 1, 0, 0, 0, '0);
        @(posedge clk_i); #1;
        drive(1'b1, W'('h91), 1'b0, '0, 1'b0);
        @(negedge clk_i); check_outs("mr_fill1", 1, 0, 0, 1, W'('h90));
        @(posedge clk_i); #1;
        drive(1'b1, W'('h92), 1'b1, W'('h93), 1'b0);
        @(negedge clk_i); check_outs("mr_full", 0, 0, 0, 1, W'('h90));
        #1 reset_i = 1'b1;
        #1 check_outs("mr_async", 0, 0, 0, 0, '0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        drive(1'b1, W'('hA0), 1'b0, '0, 1'b1);
        @(negedge clk_i); check_outs("mr_post0", 1, 0, 0, 0, '0);
        @(posedge clk_i); #1;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk_i); check_outs("mr_post1", 0, 0, 0, 1, W'('hA0));
        @(posedge clk_i); #1;
        @(negedge clk_i); check_outs("mr_post2", 0, 0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_lce_resp_arb.md
# bp_fe_lce_resp_arb

Arbitrates the I-cache LCE's two response sources onto the single outbound LCE response channel toward the CCE. The two sources are transfer responses from the request engine and sync/invalidate acks from the command engine. It replaces the combinational fixed-priority mux with the following:
- a registered 2-entry output buffer, which cuts the ready-to-valid path;
- request-source priority with a starvation bound that guarantees the command source is eventually served.

## Interface
Parameters:
- resp_width_p, 64, width of one LCE response packet (lce_cce_resp_width)
- starve_limit_p, 4, consecutive denied cycles of the command source before it is force-granted; must be ≥1

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- req_resp_i  in  resp_width_p  response from request engine
- req_resp_v_i  in  1  request-source valid
- req_resp_yumi_o  out  1  request-source consumed this cycle
- cmd_resp_i  in  resp_width_p  response from command engine
- cmd_resp_v_i  in  1  command-source valid
- cmd_resp_yumi_o  out  1  command-source consumed this cycle
- lce_resp_o  out  resp_width_p  outbound response (head of buffer)
- lce_resp_v_o  out  1  outbound valid
- lce_resp_ready_i  in  1  network ready
- starve_grant_o  out  1  pulse: this cycle's grant was forced by the starvation bound

## Operation
- Buffer: 2-entry FIFO.
  - Count is 0..2; read and write pointers are 1 bit each and wrap.
  - Dequeue = lce_resp_v_o & lce_resp_ready_i.
  - Space = (count<2) | dequeue. A full buffer accepts when the head leaves the same cycle.
- Grant, evaluated only when space=1:
  - If starve_cnt == starve_limit_p and cmd_resp_v_i: grant cmd, starve_grant_o=1.
  - Else if req_resp_v_i: grant req.
  - Else if cmd_resp_v_i: grant cmd.
  - Else no grant.
- At most one yumi per cycle. A yumi is never asserted without its valid. Yumi implies enqueue of that source's packet.
- Sources hold the packet stable while valid is high and yumi is low. The block samples data only on yumi.
- starve_cnt, width clog2(starve_limit_p+1):
  - Increments, saturating at starve_limit_p, when cmd_resp_v_i=1 and cmd is not granted. This applies whether req was granted or space=0.
  - Clears when cmd is granted or cmd_resp_v_i=0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Enqueue into an empty buffer: the packet appears on lce_resp_o the next cycle. There is no bypass.
- The outbound channel is valid/ready. lce_resp_o and lce_resp_v_o come from registers/FIFO storage only.

## Timing
- Reset (asynchronous assert, any cycle including mid-transfer):
  - count=0, pointers=0, starve_cnt=0.
  - lce_resp_v_o=0, req_resp_yumi_o=0, cmd_resp_yumi_o=0, starve_grant_o=0.
  - Yumis are gated low while reset_i=1.
  - Buffered packets are discarded.
- Latency: yumi in cycle t, then lce_resp_v_o=1 with that packet in cycle t+1 at the earliest.
- Throughput: 1 packet/cycle sustained with lce_resp_ready_i held high.
- Yumis are combinational from the v inputs, the buffer state and lce_resp_ready_i. There is no combinational path from v inputs to lce_resp_v_o.
- Ordering: packets leave in grant order, FIFO.
- With lce_resp_ready_i=0 and the buffer full: no yumi; starve_cnt still counts a waiting cmd source.
- starve_grant_o is combinational and coincides with cmd_resp_yumi_o.

## Test plan
- Reset: reset_i=1 mid-stream with 2 buffered packets → all outputs 0 immediately; after release the first new packet appears 1 cycle after its yumi; old packets are never seen.
- Single source: req_resp_v_i=1 for 1 cycle with packet 0xA5, ready=1 → req_resp_yumi_o=1 at t; lce_resp_v_o=1, lce_resp_o=0xA5 at t+1; v low at t+2.
- Backpressure: ready=0, req sends 3 packets P0,P1,P2 → yumi for P0 and P1 only, count=2; raise ready → P0 and P1 out on consecutive cycles, and P2 is accepted in the same cycle P0 dequeues.
- Starvation (starve_limit_p=4): both sources continuously valid, ready=1 → req granted 4 cycles, then cmd granted with starve_grant_o=1 in cycle 5, then req again; the pattern repeats with period 5; output order matches.
- Idle cmd clears the counter: cmd valid for 3 denied cycles, drops for 1 cycle, returns → the force grant occurs only after 4 further denied cycles.
- Command only: cmd_resp_v_i=1 with req idle → cmd granted immediately; starve_grant_o=0; 1 packet/cycle.
